// File: rtl/grab_pkg.sv
// Shared widths and helpers for the multi-hand grab detector.
package grab_pkg;

  localparam int HX_W_DEF      = 11;
  localparam int VY_W_DEF      = 10;
  localparam int RADIUS_SQ_DEF = 150;
  localparam int HIT_W         = 8;   // per-hand saturating hit counter
  localparam int REL_W         = 4;   // per-hand release debounce counter

  // Squared distance width: one sign bit per axis, doubled, plus a carry.
  function automatic int dist_w(input int hx_w);
    return 2 * (hx_w + 1) + 1;
  endfunction

  // Low bit of hand idx inside a packed per-hand bus.
  function automatic int lo_bit(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/hand_dist_pipe.sv
// One hand's two-stage squared-distance datapath: dx/dy, then dx^2+dy^2.
module hand_dist_pipe
  import grab_pkg::*;
#(
  parameter int HX_W = HX_W_DEF,
  parameter int VY_W = VY_W_DEF,
  localparam int DIST_W = 2 * (HX_W + 1) + 1
) (
  input  logic              clockin,
  input  logic              reset_n,
  input  logic [HX_W-1:0]   hcount,
  input  logic [VY_W-1:0]   vcount,
  input  logic [HX_W-1:0]   hand_x,
  input  logic [VY_W-1:0]   hand_y,
  output logic [DIST_W-1:0] dist_sq
);

  logic signed [HX_W:0]     r_dx_p1;
  logic signed [VY_W:0]     r_dy_p1;
  logic signed [2*HX_W+1:0] w_dx_ext;
  logic signed [2*HX_W+1:0] w_dx_sq;
  logic signed [2*VY_W+1:0] w_dy_ext;
  logic signed [2*VY_W+1:0] w_dy_sq;
  logic [DIST_W-1:0]        r_dist_p2;

  // Squares are computed at full product width so the far corner cannot wrap.
  assign w_dx_ext = {{(HX_W+1){r_dx_p1[HX_W]}}, r_dx_p1};
  assign w_dy_ext = {{(VY_W+1){r_dy_p1[VY_W]}}, r_dy_p1};
  assign w_dx_sq  = w_dx_ext * w_dx_ext;
  assign w_dy_sq  = w_dy_ext * w_dy_ext;

  // Stage 1: signed per-axis offsets from the hand.
  always_ff @(posedge clockin or negedge reset_n) begin
    if (!reset_n) begin
      r_dx_p1 <= '0;
      r_dy_p1 <= '0;
    end else begin
      r_dx_p1 <= signed'({1'b0, hcount} - {1'b0, hand_x});
      r_dy_p1 <= signed'({1'b0, vcount} - {1'b0, hand_y});
    end
  end

  // Stage 2: unsigned squared distance (both squares are non-negative).
  always_ff @(posedge clockin or negedge reset_n) begin
    if (!reset_n) begin
      r_dist_p2 <= '0;
    end else begin
      r_dist_p2 <= {1'b0, $unsigned(w_dx_sq)} + DIST_W'($unsigned(w_dy_sq));
    end
  end

  assign dist_sq = r_dist_p2;

endmodule

// File: rtl/grab_detect_multi.sv
// Per-pixel hold/hand overlap detector for NUM_HANDS hands with per-frame
// grab/vibrate commit on the (0,0) pixel, release debounce and a 3-cycle
// latency-matched sideband passthrough.
module grab_detect_multi
  import grab_pkg::*;
#(
  parameter int NUM_HANDS      = 2,
  parameter int HX_W           = HX_W_DEF,
  parameter int VY_W           = VY_W_DEF,
  parameter int RADIUS_SQ      = RADIUS_SQ_DEF,
  parameter int MIN_HITS       = 1,
  parameter int RELEASE_FRAMES = 1,
  parameter int SIDEBAND_W     = 3
) (
  input  logic                      clockin,
  input  logic                      reset_n,
  input  logic [HX_W-1:0]           hcount,
  input  logic [VY_W-1:0]           vcount,
  input  logic                      existsin,
  input  logic [SIDEBAND_W-1:0]     sideband_in,
  input  logic [NUM_HANDS*HX_W-1:0] hand_x,
  input  logic [NUM_HANDS*VY_W-1:0] hand_y,
  input  logic [NUM_HANDS-1:0]      hand_grab,
  output logic                      existsout,
  output logic [SIDEBAND_W-1:0]     sideband_out,
  output logic [NUM_HANDS-1:0]      grabbed,
  output logic [NUM_HANDS-1:0]      vibrate,
  output logic                      frame_done
);

  localparam int DIST_W = dist_w(HX_W);
  localparam logic [DIST_W-1:0] RAD_V  = DIST_W'(RADIUS_SQ);
  localparam logic [HIT_W-1:0]  MIN_V  = HIT_W'(MIN_HITS);
  localparam logic [REL_W:0]    REL_V  = (REL_W + 1)'(RELEASE_FRAMES);

  logic                  r_exists_p1, r_exists_p2, r_exists_p3;
  logic                  r_fm_p1, r_fm_p2;
  logic [NUM_HANDS-1:0]  r_grab_p1, r_grab_p2;
  logic [SIDEBAND_W-1:0] r_sb_p1, r_sb_p2, r_sb_p3;
  logic                  r_frame_done;
  logic [NUM_HANDS-1:0]  r_grabbed, r_vibrate, r_hover;
  logic [HIT_W-1:0]      r_hits [NUM_HANDS];
  logic [REL_W-1:0]      r_rel  [NUM_HANDS];

  logic [DIST_W-1:0]     w_dist     [NUM_HANDS];
  logic [REL_W:0]        w_rel_next [NUM_HANDS];
  logic [NUM_HANDS-1:0]  w_hit, w_contact, w_rel_done;
  logic                  w_fm;

  assign w_fm = (hcount == '0) && (vcount == '0);

  for (genvar i = 0; i < NUM_HANDS; i++) begin : g_hand
    hand_dist_pipe #(
      .HX_W (HX_W),
      .VY_W (VY_W)
    ) u_pipe (
      .clockin (clockin),
      .reset_n (reset_n),
      .hcount  (hcount),
      .vcount  (vcount),
      .hand_x  (hand_x[lo_bit(i, HX_W) +: HX_W]),
      .hand_y  (hand_y[lo_bit(i, VY_W) +: VY_W]),
      .dist_sq (w_dist[i])
    );

    assign w_hit[i]      = r_exists_p2 && (w_dist[i] < RAD_V);
    assign w_contact[i]  = (r_hits[i] >= MIN_V);
    assign w_rel_next[i] = {1'b0, r_rel[i]} + 1'b1;
    assign w_rel_done[i] = (w_rel_next[i] >= REL_V);
  end

  // Stages 1-3: control/sideband pipeline aligned with the distance datapath.
  always_ff @(posedge clockin or negedge reset_n) begin
    if (!reset_n) begin
      r_exists_p1 <= 1'b0;
      r_exists_p2 <= 1'b0;
      r_exists_p3 <= 1'b0;
      r_fm_p1     <= 1'b0;
      r_fm_p2     <= 1'b0;
      r_grab_p1   <= '0;
      r_grab_p2   <= '0;
      r_sb_p1     <= '0;
      r_sb_p2     <= '0;
      r_sb_p3     <= '0;
    end else begin
      r_exists_p1 <= existsin;
      r_exists_p2 <= r_exists_p1;
      r_exists_p3 <= r_exists_p2;
      r_fm_p1     <= w_fm;
      r_fm_p2     <= r_fm_p1;
      r_grab_p1   <= hand_grab;
      r_grab_p2   <= r_grab_p1;
      r_sb_p1     <= sideband_in;
      r_sb_p2     <= r_sb_p1;
      r_sb_p3     <= r_sb_p2;
    end
  end

  // Stage 3: accumulate hits/hover, and commit per-hand results on the marker.
  always_ff @(posedge clockin or negedge reset_n) begin
    if (!reset_n) begin
      r_grabbed    <= '0;
      r_vibrate    <= '0;
      r_hover      <= '0;
      r_frame_done <= 1'b0;
      for (int i = 0; i < NUM_HANDS; i++) begin
        r_hits[i] <= '0;
        r_rel[i]  <= '0;
      end
    end else begin
      r_frame_done <= r_fm_p2;
      for (int i = 0; i < NUM_HANDS; i++) begin
        if (r_fm_p2) begin
          // Commit uses last frame's totals; the marker pixel opens the new frame.
          if (r_grab_p2[i]) begin
            r_rel[i]     <= '0;
            r_grabbed[i] <= r_grabbed[i] | w_contact[i];
          end else if (w_rel_done[i]) begin
            r_rel[i]     <= '0;
            r_grabbed[i] <= 1'b0;
          end else if (r_rel[i] != '1) begin
            r_rel[i]     <= r_rel[i] + 1'b1;
          end
          r_vibrate[i] <= r_hover[i];
          r_hits[i]    <= (r_grab_p2[i] && w_hit[i]) ? HIT_W'(1) : '0;
          r_hover[i]   <= !r_grab_p2[i] && w_hit[i];
        end else if (r_grab_p2[i]) begin
          if (w_hit[i] && (r_hits[i] != '1)) begin
            r_hits[i] <= r_hits[i] + 1'b1;
          end
        end else if (w_hit[i]) begin
          r_hover[i] <= 1'b1;
        end
      end
    end
  end

  assign existsout    = r_exists_p3;
  assign sideband_out = r_sb_p3;
  assign grabbed      = r_grabbed;
  assign vibrate      = r_vibrate;
  assign frame_done   = r_frame_done;

endmodule

// File: tb/tb_grab_detect_multi.sv
// Directed bench for grab_detect_multi: a default instance (A) and one with
// MIN_HITS=4, RELEASE_FRAMES=3 (B) share the same pixel stream.
module tb_grab_detect_multi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        existsin;
  logic [2:0]  sideband_in;
  logic [21:0] hand_x;
  logic [19:0] hand_y;
  logic [1:0]  hand_grab;

  logic        existsout_a, existsout_b, frame_done_a, frame_done_b;
  logic [2:0]  sideband_out_a, sideband_out_b;
  logic [1:0]  grabbed_a, grabbed_b, vibrate_a, vibrate_b;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  grab_detect_multi u_dut_a (
    .clockin (clk), .reset_n (rst_n), .hcount (hcount), .vcount (vcount),
    .existsin (existsin), .sideband_in (sideband_in), .hand_x (hand_x),
    .hand_y (hand_y), .hand_grab (hand_grab), .existsout (existsout_a),
    .sideband_out (sideband_out_a), .grabbed (grabbed_a), .vibrate (vibrate_a),
    .frame_done (frame_done_a)
  );

  grab_detect_multi #(.MIN_HITS (4), .RELEASE_FRAMES (3)) u_dut_b (
    .clockin (clk), .reset_n (rst_n), .hcount (hcount), .vcount (vcount),
    .existsin (existsin), .sideband_in (sideband_in), .hand_x (hand_x),
    .hand_y (hand_y), .hand_grab (hand_grab), .existsout (existsout_b),
    .sideband_out (sideband_out_b), .grabbed (grabbed_b), .vibrate (vibrate_b),
    .frame_done (frame_done_b)
  );

  task automatic set_hand(input int idx, input logic [10:0] x, input logic [9:0] y);
    hand_x[idx*11 +: 11] = x;
    hand_y[idx*10 +: 10] = y;
  endtask

  // Present one pixel for one clock, then settle just after the edge.
  task automatic pix(input logic [10:0] h, input logic [9:0] v, input logic e);
    hcount   = h;
    vcount   = v;
    existsin = e;
    @(posedge clk);
    #1;
  endtask

  // Marker pixel plus two fillers: the commit is visible after the third.
  task automatic commit_frame();
    pix(11'd0, 10'd0, 1'b0);
    pix(11'd1, 10'd1, 1'b0);
    pix(11'd2, 10'd1, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    hcount = '0; vcount = '0; existsin = 1'b1; sideband_in = 3'b111;
    hand_x = '0; hand_y = '0; hand_grab = 2'b11;
    set_hand(0, 11'd100, 10'd100);
    set_hand(1, 11'd500, 10'd500);
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({existsout_a, existsout_b, sideband_out_a, sideband_out_b} !== 8'h00)
      $display("FAIL reset_passthru got %b exp 0", {existsout_a, existsout_b, sideband_out_a, sideband_out_b});
    else n_pass++;
    n_total++;
    if ({grabbed_a, grabbed_b, vibrate_a, vibrate_b, frame_done_a, frame_done_b} !== 10'd0)
      $display("FAIL reset_state got %b exp 0", {grabbed_a, grabbed_b, vibrate_a, vibrate_b, frame_done_a, frame_done_b});
    else n_pass++;
    existsin = 1'b0; sideband_in = '0; hand_grab = 2'b00;
    rst_n = 1'b1;
  endtask

  task automatic test_passthrough();
    logic       ex_hist [10];
    logic [2:0] sb_hist [10];
    for (int k = 0; k < 10; k++) begin
      ex_hist[k]  = k[0] ^ k[1];
      sb_hist[k]  = 3'((k * 3) % 8);
      sideband_in = sb_hist[k];
      pix(11'(10 + k), 10'd5, ex_hist[k]);
      if (k >= 2) begin
        n_total++;
        if ({existsout_a, sideband_out_a, existsout_b, sideband_out_b} !==
            {ex_hist[k-2], sb_hist[k-2], ex_hist[k-2], sb_hist[k-2]})
          $display("FAIL passthru_%0d got %b exp %b", k,
                   {existsout_a, sideband_out_a, existsout_b, sideband_out_b},
                   {ex_hist[k-2], sb_hist[k-2], ex_hist[k-2], sb_hist[k-2]});
        else n_pass++;
      end
    end
    sideband_in = '0;
    pix(11'd0, 10'd0, 1'b0);
    pix(11'd1, 10'd1, 1'b0);
    n_total++;
    if ({frame_done_a, frame_done_b} !== 2'b00)
      $display("FAIL frame_done_early got %b exp 00", {frame_done_a, frame_done_b});
    else n_pass++;
    pix(11'd2, 10'd1, 1'b0);
    n_total++;
    if ({frame_done_a, frame_done_b} !== 2'b11)
      $display("FAIL frame_done_pulse got %b exp 11", {frame_done_a, frame_done_b});
    else n_pass++;
    n_total++;
    if ({grabbed_a, grabbed_b, vibrate_a, vibrate_b} !== 8'h00)
      $display("FAIL empty_frame got %b exp 0", {grabbed_a, grabbed_b, vibrate_a, vibrate_b});
    else n_pass++;
    pix(11'd3, 10'd1, 1'b0);
    n_total++;
    if ({frame_done_a, frame_done_b} !== 2'b00)
      $display("FAIL frame_done_single got %b exp 00", {frame_done_a, frame_done_b});
    else n_pass++;
  endtask

  task automatic test_grab_hit();
    hand_grab = 2'b11;
    set_hand(0, 11'd100, 10'd100);
    set_hand(1, 11'd500, 10'd500);
    commit_frame();
    pix(11'd105, 10'd108, 1'b1);
    commit_frame();
    n_total++;
    if ({grabbed_a, grabbed_b} !== 4'b0100)
      $display("FAIL grab_hit got %b exp 0100", {grabbed_a, grabbed_b});
    else n_pass++;
    n_total++;
    if ({vibrate_a, vibrate_b} !== 4'b0000)
      $display("FAIL grab_no_vibrate got %b exp 0000", {vibrate_a, vibrate_b});
    else n_pass++;
    set_hand(0, 11'd300, 10'd300);
    commit_frame();
    n_total++;
    if (grabbed_a !== 2'b01)
      $display("FAIL grab_sticky got %b exp 01", grabbed_a);
    else n_pass++;
    hand_grab = 2'b00;
    commit_frame();
    n_total++;
    if (grabbed_a !== 2'b00)
      $display("FAIL release_a got %b exp 00", grabbed_a);
    else n_pass++;
  endtask

  task automatic test_hover();
    hand_grab = 2'b00;
    set_hand(0, 11'd100, 10'd100);
    commit_frame();
    pix(11'd112, 10'd100, 1'b1);
    commit_frame();
    n_total++;
    if ({vibrate_a, vibrate_b, grabbed_a} !== 6'b010100)
      $display("FAIL hover_144 got %b exp 010100", {vibrate_a, vibrate_b, grabbed_a});
    else n_pass++;
    pix(11'd113, 10'd100, 1'b1);
    commit_frame();
    n_total++;
    if ({vibrate_a, vibrate_b} !== 4'b0000)
      $display("FAIL hover_169 got %b exp 0000", {vibrate_a, vibrate_b});
    else n_pass++;
  endtask

  task automatic test_min_hits();
    hand_grab = 2'b11;
    set_hand(0, 11'd100, 10'd100);
    commit_frame();
    pix(11'd105, 10'd108, 1'b1);
    pix(11'd100, 10'd100, 1'b1);
    pix(11'd101, 10'd101, 1'b1);
    commit_frame();
    n_total++;
    if ({grabbed_a, grabbed_b} !== 4'b0100)
      $display("FAIL min_hits_3 got %b exp 0100", {grabbed_a, grabbed_b});
    else n_pass++;
    pix(11'd105, 10'd108, 1'b1);
    pix(11'd100, 10'd100, 1'b1);
    pix(11'd101, 10'd101, 1'b1);
    pix(11'd99, 10'd99, 1'b1);
    commit_frame();
    n_total++;
    if (grabbed_b !== 2'b01)
      $display("FAIL min_hits_4 got %b exp 01", grabbed_b);
    else n_pass++;
  endtask

  task automatic test_release();
    hand_grab = 2'b00;
    commit_frame();
    n_total++;
    if ({grabbed_a, grabbed_b} !== 4'b0001)
      $display("FAIL release_c1 got %b exp 0001", {grabbed_a, grabbed_b});
    else n_pass++;
    hand_grab = 2'b11;
    commit_frame();
    n_total++;
    if (grabbed_b !== 2'b01)
      $display("FAIL regrab_c2 got %b exp 01", grabbed_b);
    else n_pass++;
    hand_grab = 2'b00;
    commit_frame();
    commit_frame();
    n_total++;
    if (grabbed_b !== 2'b01)
      $display("FAIL release_debounce got %b exp 01", grabbed_b);
    else n_pass++;
    commit_frame();
    n_total++;
    if (grabbed_b !== 2'b00)
      $display("FAIL release_third got %b exp 00", grabbed_b);
    else n_pass++;
  endtask

  task automatic test_wrap();
    hand_grab = 2'b00;
    set_hand(0, 11'd0, 10'd0);
    set_hand(1, 11'd0, 10'd0);
    commit_frame();
    pix(11'd2047, 10'd1023, 1'b1);
    pix(11'd2047, 10'd0, 1'b1);
    pix(11'd0, 10'd1023, 1'b1);
    commit_frame();
    n_total++;
    if ({vibrate_a, vibrate_b} !== 4'b0000)
      $display("FAIL max_dist got %b exp 0000", {vibrate_a, vibrate_b});
    else n_pass++;
    pix(11'd3, 10'd4, 1'b1);
    commit_frame();
    n_total++;
    if ({vibrate_a, vibrate_b} !== 4'b1111)
      $display("FAIL twin_hands got %b exp 1111", {vibrate_a, vibrate_b});
    else n_pass++;
  endtask

  task automatic test_reset_midframe();
    hand_grab   = 2'b11;
    sideband_in = 3'b101;
    repeat (4) pix(11'd1, 10'd1, 1'b1);
    rst_n = 1'b0;
    #2;
    n_total++;
    if ({existsout_a, sideband_out_a, grabbed_a, vibrate_a, frame_done_a,
         existsout_b, sideband_out_b, grabbed_b, vibrate_b, frame_done_b} !== 18'd0)
      $display("FAIL async_reset got %b exp 0",
               {existsout_a, sideband_out_a, grabbed_a, vibrate_a, frame_done_a,
                existsout_b, sideband_out_b, grabbed_b, vibrate_b, frame_done_b});
    else n_pass++;
    sideband_in = '0;
    pix(11'd1, 10'd1, 1'b0);
    pix(11'd1, 10'd1, 1'b0);
    rst_n = 1'b1;
    commit_frame();
    n_total++;
    if ({frame_done_a, grabbed_a, vibrate_a, grabbed_b, vibrate_b} !== 9'b100000000)
      $display("FAIL post_reset_commit got %b exp 100000000",
               {frame_done_a, grabbed_a, vibrate_a, grabbed_b, vibrate_b});
    else n_pass++;
    pix(11'd1, 10'd1, 1'b1);
    commit_frame();
    n_total++;
    if ({grabbed_a, grabbed_b} !== 4'b1100)
      $display("FAIL post_reset_grab got %b exp 1100", {grabbed_a, grabbed_b});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_grab_hit();
    test_hover();
    test_min_hits();
    test_release();
    test_wrap();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/grab_detect_multi.md
Name: grab_detect_multi

Overview:
Parametrised successor to the per-pixel hand/hold overlap detector in the climber video pipeline. It sits in the pixel stream after the hold renderer. It compares every pixel flagged as a hold (existsin) against NUM_HANDS hand positions using a pipelined squared-distance test, and commits per-frame grab and vibrate results on a synchronous frame boundary rather than a vsync edge. It adds a configurable contact threshold, release debounce and a latency-matched sideband passthrough.

Parameters:
NUM_HANDS, 2, number of tracked hands (1..4)
HX_W, 11, hcount / hand-x width
VY_W, 10, vcount / hand-y width
RADIUS_SQ, 150, overlap when dx^2+dy^2 < RADIUS_SQ (strict)
MIN_HITS, 1, overlapping hold pixels per frame required for contact (1..255)
RELEASE_FRAMES, 1, consecutive frames with grab low before a grab drops (1..15)
SIDEBAND_W, 3, width of the delayed passthrough bus (e.g. hsync, vsync, blank)

Ports:
clockin  in  1  pixel clock (65 MHz)
reset_n  in  1  asynchronous active-low reset
hcount  in  HX_W  current pixel column
vcount  in  VY_W  current pixel row
existsin  in  1  current pixel is part of a hold
sideband_in  in  SIDEBAND_W  pixel-aligned signals to delay
hand_x  in  NUM_HANDS*HX_W  packed hand x; hand i in [i*HX_W +: HX_W]
hand_y  in  NUM_HANDS*VY_W  packed hand y
hand_grab  in  NUM_HANDS  user grab button per hand
existsout  out  1  existsin delayed by 3
sideband_out  out  SIDEBAND_W  sideband_in delayed by 3
grabbed  out  NUM_HANDS  per-hand grab state, frame-latched
vibrate  out  NUM_HANDS  hand hovered a hold last frame without grabbing
frame_done  out  1  one-cycle pulse on each commit

Behaviour:
- Reset (async assert, sync release): all pipeline registers, accumulators, release counters, existsout, sideband_out, grabbed, vibrate and frame_done are cleared to 0.
- Stage 1: register per-hand dx = hcount - hand_x and dy = vcount - hand_y as signed HX_W+1 / VY_W+1 values. Also register existsin, hand_grab, sideband_in and the frame marker fm = (hcount==0 && vcount==0).
- Stage 2: register dx^2 + dy^2, unsigned, width 2*(HX_W+1)+1. No truncation; the largest distance must not wrap into a hit.
- Stage 3: hit_i = exists_s2 && (dist_i < RADIUS_SQ).
  - grab_s2[i]=1: saturating 8-bit grab_hits_i += hit_i.
  - grab_s2[i]=0: hover_i |= hit_i.
- Passthrough latency is exactly 3 cycles for existsout and sideband_out.
- Commit occurs in the cycle fm reaches stage 3.
  - contact_i = grab_hits_i >= MIN_HITS. Use the accumulator value from before this cycle; the fm pixel belongs to the new frame.
  - g = hand_grab sampled at stage 3 of the fm pixel.
  - g=1: rel_cnt_i <= 0; grabbed_i <= grabbed_i | contact_i. A grab held from the last frame sticks even with no contact.
  - g=0: if rel_cnt_i+1 >= RELEASE_FRAMES then grabbed_i <= 0 and rel_cnt_i <= 0, else rel_cnt_i++. rel_cnt saturates.
  - vibrate_i <= hover_i.
  - frame_done <= 1 for one cycle.
  - Accumulators restart with the fm pixel's own hit only (clear plus same-cycle accumulate).
- Before the first commit after reset, grabbed and vibrate stay 0.
- Frames are defined only by fm. No fm means no commit, and accumulators saturate and hold.
- Hands are independent; identical positions produce identical results.
- Reset mid-frame discards partial accumulation.

Decomposition:
- Shared package grab_pkg: default widths, RADIUS_SQ default, hit-counter width (8), rel_cnt width (4), and a packing helper/localparam for hand_x/hand_y slices.
- One sub-module, hand_dist_pipe: one hand's 2-stage dx/dy to squared-distance datapath. It is instantiated NUM_HANDS times via generate. The top level holds the frame marker pipeline, accumulators and commit logic.

Test Plan:
- Reset release, existsin=0 for a full frame -> grabbed=0, vibrate=0, frame_done pulses once per frame at fm+3, existsout/sideband_out equal inputs delayed 3.
- Hand0 at (100,100), grab=1, hold pixel at (105,108) (dist 89) -> grabbed[0]=1 at next commit; hand1 unaffected.
- Hold pixel at (112,100) (dist 144) vs (113,100) (dist 169), hand0 grab=0 -> vibrate[0]=1 for 144, vibrate[0]=0 for 169; grabbed stays 0.
- MIN_HITS=4, only 3 overlapping hold pixels with grab=1 -> grabbed[0]=0; add a 4th -> grabbed[0]=1.
- grabbed[0]=1, hand moved away, grab stays 1 -> grabbed remains 1. RELEASE_FRAMES=3 with grab low -> drops at the 3rd commit. Grab high again at the 2nd commit -> remains 1 and the counter resets.
- hand_x=0, hcount=2047 (max wrap distance) with existsin=1 -> no hit. Assert reset_n mid-frame -> all outputs 0 immediately, and the next frame behaves as from power-up.
